// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: request/response handshake plus memory bus of the controller
interface mem_req_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic init_done;
  logic mem_read;
  logic mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
    input req_ready, rsp_valid, rsp_rdata, init_done, mem_read, mem_write, mem_addr, mem_data_in
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, init_done, mem_read, mem_write, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: single-outstanding request front-end for a synchronous memory, with optional post-reset scrub
module mem_req_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int INIT_CLEAR = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input logic clk,
  input logic rst_n,
  mem_req_ctrl_if.slave bus
);
  typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, RWAIT, RESP} state_t;
  localparam logic [ADDR_W:0] LAST = {1'b1, {ADDR_W{1'b0}}};
  state_t state, state_nx;
  logic [ADDR_W:0] cnt, cnt_nx;
  logic req_ready_nx, rsp_valid_nx, init_done_nx, mem_read_nx, mem_write_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_data_in_nx, rsp_rdata_nx;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    req_ready_nx = 1'b0;
    mem_read_nx = 1'b0;
    mem_write_nx = 1'b0;
    mem_addr_nx = bus.mem_addr;
    mem_data_in_nx = bus.mem_data_in;
    rsp_valid_nx = bus.rsp_valid;
    rsp_rdata_nx = bus.rsp_rdata;
    init_done_nx = bus.init_done;
    case (state)
      INIT: begin
        if (cnt == LAST) begin
          state_nx = IDLE;
          init_done_nx = 1'b1;
          req_ready_nx = 1'b1;
        end else begin
          mem_write_nx = 1'b1;
          mem_addr_nx = cnt[ADDR_W-1:0];
          mem_data_in_nx = INIT_VALUE;
          cnt_nx = cnt + 1'b1;
        end
      end
      IDLE: begin
        init_done_nx = 1'b1;
        req_ready_nx = 1'b1;
        // the request is launched straight onto the memory bus at the accept edge
        if (bus.req_valid && bus.req_ready) begin
          req_ready_nx = 1'b0;
          state_nx = bus.req_write ? WRITE : READ;
          mem_write_nx = bus.req_write;
          mem_read_nx = !bus.req_write;
          mem_addr_nx = bus.req_addr;
          mem_data_in_nx = bus.req_write ? bus.req_wdata : bus.mem_data_in;
        end
      end
      WRITE: begin
        state_nx = IDLE;
        req_ready_nx = 1'b1;
      end
      READ: state_nx = RWAIT;
      RWAIT: begin
        rsp_valid_nx = 1'b1;
        rsp_rdata_nx = bus.mem_data_out;
        state_nx = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nx = 1'b0;
          req_ready_nx = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (INIT_CLEAR != 0) ? INIT : IDLE;
      cnt <= '0;
      bus.req_ready <= 1'b0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data_in <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.init_done <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bus.req_ready <= req_ready_nx;
      bus.mem_read <= mem_read_nx;
      bus.mem_write <= mem_write_nx;
      bus.mem_addr <= mem_addr_nx;
      bus.mem_data_in <= mem_data_in_nx;
      bus.rsp_valid <= rsp_valid_nx;
      bus.rsp_rdata <= rsp_rdata_nx;
      bus.init_done <= init_done_nx;
    end
  end
endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request/response front-end that sits directly upstream of the synchronous 8x32 memory and is the only master of its bus. It accepts single read or write requests over a valid/ready handshake, drives the memory's `read`/`write`/`addr`/`data_in` with registered one-cycle pulses, and captures `data_out` into a held response. After reset it optionally scrubs every memory location to a known value before it accepts traffic.

## Interface
- `ADDR_W`, 5: memory address width; depth is `2**ADDR_W`.
- `DATA_W`, 8: data width.
- `INIT_CLEAR`, 1: 1 = scrub all locations after reset; 0 = go straight to IDLE.
- `INIT_VALUE`, `'0`: value written to every location during the scrub.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: request address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: read data available.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out DATA_W: read data.
- `init_done` out 1: scrub finished, sticky until reset.
- `mem_read` out 1: to memory `read`.
- `mem_write` out 1: to memory `write`.
- `mem_addr` out ADDR_W: to memory `addr`.
- `mem_data_in` out DATA_W: to memory `data_in`.
- `mem_data_out` in DATA_W: from memory `data_out`.

## Operation
- All outputs are registered. `rst_n` low at an edge forces every output to 0 on that edge, state goes to INIT (or IDLE if `INIT_CLEAR`=0) and the scrub counter goes to 0. `init_done` resets to 0.
- Reset abandons any in-flight operation: no response is produced, and the memory pulse is dropped on the next edge.
- INIT: `mem_write`=1, `mem_addr`=counter, `mem_data_in`=`INIT_VALUE` for counters 0..`2**ADDR_W-1`, one per cycle. After the last address is written, state goes to IDLE and `init_done` is set. `req_ready`=0 throughout.
- With `INIT_CLEAR`=0, `init_done` is 1 from the first cycle after reset.
- IDLE: `req_ready`=1, `mem_read`=`mem_write`=0. A request is accepted on an edge where `req_valid` and `req_ready` are both high. At that edge the address, data and type are registered and `req_ready` drops.
- WRITE (1 cycle): `mem_write`=1 with the registered address and data. Next state is IDLE.
- READ (1 cycle): `mem_read`=1 with the registered address. Next state is RWAIT.
- RWAIT (1 cycle): both strobes are 0. The memory's `data_out` is valid in this cycle. On the edge that ends the cycle, `mem_data_out` is captured into `rsp_rdata`, `rsp_valid` is set, and the state becomes RESP.
- RESP: `rsp_valid` and `rsp_rdata` are held stable until an edge with `rsp_ready`=1. That edge clears `rsp_valid` and returns to IDLE. `rsp_rdata` holds its last value after the response is taken.
- Invariants:
  - `mem_read` and `mem_write` are never high in the same cycle.
  - Each strobe is high for exactly one cycle per request.
  - Only one request is outstanding at a time.
- Address arithmetic: the scrub counter is `ADDR_W+1` bits wide and terminates at `2**ADDR_W`. Request addresses are used unmodified, with no wrap or offset.

## Timing
- E0 is the accept edge.
- Write: `mem_write` is high in cycle E0..E1, and the memory stores the word at E1. `req_ready` is high again after E1. Throughput is 1 write per 2 cycles.
- Read: `mem_read` is high in E0..E1, the memory loads `data_out` at E1, and the controller captures at E2. `rsp_valid` is high from E2. With `rsp_ready` held 1, the earliest next accept is E4 (E3 returns to IDLE), giving 4 cycles per read.
- Scrub takes exactly `2**ADDR_W` cycles of `mem_write` (32 by default). `init_done` and `req_ready` rise on the edge that ends the last scrub write.
- `req_*` are sampled only at the accept edge. Changing them later has no effect.
- A `rsp_ready` high while `rsp_valid` is 0 is ignored.

## Test plan
- Reset then scrub (`INIT_VALUE`=8'hA5): exactly 32 `mem_write` pulses to addresses 0..31 in order, then `init_done`=1 and `req_ready`=1. Reading address 17 then returns 8'hA5.
- Write 8'h3C to address 5, then read address 5 with `rsp_ready`=1: `mem_write` is high for one cycle with addr 5 and data 8'h3C. `rsp_valid` rises 2 edges after the read accept, with `rsp_rdata`=8'h3C.
- Backpressure: read address 31 (previously written 8'hF0) with `rsp_ready`=0 for 5 cycles. `rsp_valid` and `rsp_rdata`=8'hF0 stay stable and `req_ready`=0 throughout. Raising `rsp_ready` for one edge clears `rsp_valid`.
- Back-to-back requests with `req_valid` held high (write address 0 = 8'h11, write address 1 = 8'h22, read address 0): acceptances occur every 2 cycles for the writes. The read returns 8'h11, and the strobes never overlap.
- Reset in mid-flight: assert `rst_n`=0 in RWAIT. `rsp_valid` never rises, all outputs are 0 one edge later, and the scrub restarts at address 0.
- `INIT_CLEAR`=0: `init_done`=1 and `req_ready`=1 in the first cycle after reset deasserts, with no `mem_write` pulses.
